instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch-stage PC sequencer for the pipelined MIPS core. Owns the program counter, issues word fetches to instruction memory over a request/acknowledge handshake, and delivers instruction words with their PC+4 to decode through a one-entry output register plus a one-entry skid buffer. Consumes the jump/branch target computed in decode (`Alt_PC`, `Request_Alt_PC`) and applies it after the branch delay slot.

## Interface
- `RESET_PC`, 32'hBFC00000, PC loaded on reset; first fetch address.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `STALL`  in  1  decode cannot accept; holds output register.
- `Request_Alt_PC`  in  1  redirect pulse from decode, asserted in the cycle a taken jump/branch is consumed.
- `Alt_PC`  in  32  redirect target, valid with `Request_Alt_PC`.
- `IMem_Req`  out  1  fetch request.
- `IMem_Addr`  out  32  fetch address (word-aligned).
- `IMem_Ack`  in  1  fetch complete; `IMem_Data` valid this cycle.
- `IMem_Data`  in  32  fetched instruction word.
- `Instr`  out  32  instruction to decode.
- `Instr_PC_Plus4`  out  32  address of `Instr` + 4.
- `Instr_Valid`  out  1  `Instr`/`Instr_PC_Plus4` valid.

## Operation
- Registers: `PC` (address of the next instruction not yet delivered), output slot {`Instr`, `Instr_PC_Plus4`, `Instr_Valid`}, skid {data, valid}, pending redirect {target, valid}, state.
- Reset values: `PC`=`RESET_PC`, state=REQ, `Instr`=0, `Instr_PC_Plus4`=0, `Instr_Valid`=0, skid valid=0, pending valid=0. `IMem_Req`=0 while `RESET` low.
- Consume: output slot consumed in any cycle with `Instr_Valid`=1 and `STALL`=0. Slot free = `!Instr_Valid || !STALL`.
- States:
  - REQ: `IMem_Req`=1, `IMem_Addr`=`PC`, both held until ack. On `IMem_Ack`: if slot free, load `Instr`=`IMem_Data`, `Instr_PC_Plus4`=`PC`+4, `Instr_Valid`=1, advance PC, stay REQ; else write skid, go SKID.
  - SKID: `IMem_Req`=0. When slot free: move skid to output (`Instr_PC_Plus4`=`PC`+4), clear skid, advance PC, go REQ.
- If slot consumed and nothing loaded that cycle, `Instr_Valid`<=0.
- PC advance (the only PC update): next = `Alt_PC` if `Request_Alt_PC` this cycle, else pending target if pending valid, else `PC`+4 (mod 2^32). Pending valid cleared on every advance.
- `Request_Alt_PC` with no advance in that cycle: latch `Alt_PC` into pending, set valid. Second redirect before advance overwrites pending.
- Delay slot: at the cycle decode consumes a branch, `PC` = branch+4, so the advance that delivers the delay slot loads the target. Delay-slot instruction is always delivered; never squashed.
- Low 2 bits of `Alt_PC` passed through unchanged (no alignment check).

## Timing
- First `IMem_Req` visible in the first cycle after `RESET` deasserts.
- Zero-wait memory (`IMem_Ack` high whenever `IMem_Req` high): one instruction per cycle; `Instr_Valid` rises at first rising edge with ack.
- Fetch latency: `Instr` valid the edge `IMem_Ack` is sampled high; 0 extra cycles.
- Stall with full output: at most one further ack absorbed into skid; then `IMem_Req`=0 until release. Release: skid delivered at the next edge, `IMem_Req` reasserted the same cycle at the advanced PC.
- `IMem_Addr` changes only on an advance; stable while `IMem_Req`=1 and no ack.
- `RESET` asserted mid-request: `IMem_Req`, `Instr_Valid` drop immediately (no clock); any late ack after release is ignored only if it arrives while `IMem_Req`=0.
- No duplicate or lost instruction across any stall/redirect combination.

## Test plan
- Reset release, ack tied 1, `IMem_Data`=address -> `Instr_PC_Plus4` = BFC00004, BFC00008, BFC0000C on consecutive edges; `Instr`=`Instr_PC_Plus4`-4.
- `STALL`=1 for 3 cycles while delivering BFC00004 -> skid holds BFC00004 word, `IMem_Req`=0 cycles 2-3, output frozen; release -> BFC00004 then BFC00008 words, no gaps/repeats.
- Consume branch (`Instr_PC_Plus4`=BFC0000C) with `Request_Alt_PC`=1, `Alt_PC`=BFC00100 -> next deliveries BFC0000C (delay slot) then BFC00100, BFC00104.
- Same redirect with memory ack delayed 2 cycles -> pending latched; `IMem_Addr` BFC0000C held 3 cycles, then BFC00100.
- Redirect while skid full and stalled, then release -> skid word delivered, next `IMem_Addr`=`Alt_PC`.
- `RESET` low mid-request at `IMem_Addr`=BFC00010 -> `IMem_Req`=0, `Instr_Valid`=0 immediately; after release fetch restarts at BFC00000.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/acknowledge plus the decode-side
// delivery and redirect signals. The fetch unit is the master.
`timescale 1ns/1ps
interface instruction_fetch_unit_if;
  logic        STALL;
  logic        Request_Alt_PC;
  logic [31:0] Alt_PC;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;
  logic [31:0] Instr;
  logic [31:0] Instr_PC_Plus4;
  logic        Instr_Valid;

  modport master (
    input  STALL, Request_Alt_PC, Alt_PC, IMem_Ack, IMem_Data,
    output IMem_Req, IMem_Addr, Instr, Instr_PC_Plus4, Instr_Valid
  );

  modport slave (
    output STALL, Request_Alt_PC, Alt_PC, IMem_Ack, IMem_Data,
    input  IMem_Req, IMem_Addr, Instr, Instr_PC_Plus4, Instr_Valid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch-stage PC sequencer: word fetches over req/ack, one output slot plus a
// one-entry skid, redirects applied after the branch delay slot.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input logic                        CLK,
  input logic                        RESET,
  instruction_fetch_unit_if.master   bus
);

  typedef enum logic {ST_REQ, ST_SKID} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic [31:0] skid_q;
  logic [31:0] pend_pc_q;
  logic        pend_v_q;

  logic        slot_free;
  logic        consume;
  logic        load_fetch;
  logic        load_skid;
  logic        advance;
  logic [31:0] pc_d;

  assign slot_free  = !valid_q || !bus.STALL;
  assign consume    = valid_q && !bus.STALL;
  assign load_fetch = (state_q == ST_REQ) && bus.IMem_Ack && slot_free;
  assign load_skid  = (state_q == ST_SKID) && slot_free;
  assign advance    = load_fetch || load_skid;

  // A redirect seen in the advancing cycle wins; otherwise a latched one.
  assign pc_d = bus.Request_Alt_PC ? bus.Alt_PC :
                pend_v_q           ? pend_pc_q  : pc_q + 32'd4;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      pend_v_q <= 1'b0;
    end else begin
      if (advance) begin
        instr_q  <= load_skid ? skid_q : bus.IMem_Data;
        pc4_q    <= pc_q + 32'd4;
        valid_q  <= 1'b1;
        pc_q     <= pc_d;
        pend_v_q <= 1'b0;
      end else begin
        if (consume)            valid_q  <= 1'b0;
        if (bus.Request_Alt_PC) pend_v_q <= 1'b1;
      end

      case (state_q)
        ST_REQ:  if (bus.IMem_Ack && !slot_free) state_q <= ST_SKID;
        ST_SKID: if (slot_free)                  state_q <= ST_REQ;
        default:                                 state_q <= ST_REQ;
      endcase
    end
  end

  // NOTE: skid word and pending target are only read when their valid/state
  // qualifier is set, so they carry no reset and stay plain enable flops.
  always_ff @(posedge CLK) begin
    if ((state_q == ST_REQ) && bus.IMem_Ack && !slot_free) skid_q <= bus.IMem_Data;
    if (!advance && bus.Request_Alt_PC)                    pend_pc_q <= bus.Alt_PC;
  end

  // Request drops combinationally with reset so no fetch is seen while held.
  assign bus.IMem_Req       = RESET && (state_q == ST_REQ);
  assign bus.IMem_Addr      = pc_q;
  assign bus.Instr          = instr_q;
  assign bus.Instr_PC_Plus4 = pc4_q;
  assign bus.Instr_Valid    = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written
// redirect/skid/reset sequences, and randomized traffic against a stream model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.RESET_PC(BASE)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs for the coming rising edge, then wait to the next falling edge.
  task automatic cyc(input logic stall, input logic ack, input logic redir, input logic [31:0] alt);
    bus.STALL          = stall;
    bus.IMem_Ack       = ack;
    bus.Request_Alt_PC = redir;
    bus.Alt_PC         = alt;
    bus.IMem_Data      = bus.IMem_Addr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n              = 1'b0;
    bus.STALL          = 1'b0;
    bus.IMem_Ack       = 1'b0;
    bus.Request_Alt_PC = 1'b0;
    bus.Alt_PC         = '0;
    bus.IMem_Data      = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct packed {
    logic        stall;
    logic        ack;
    logic        redir;
    logic [31:0] alt;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] exp_next, after_pc, rnd, alt, prev_addr;
    logic        after_v, stall, ack, redir, consume, prev_req, prev_ack;
    int          n_cons;

    // stall, ack, redir, alt, expected req, valid, addr, instr (before the edge)
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, BASE + 32'h000, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, BASE + 32'h004, BASE + 32'h000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1, BASE + 32'h004, BASE + 32'h000};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, BASE + 32'h004, BASE + 32'h000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1, BASE + 32'h004, BASE + 32'h000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, BASE + 32'h008, BASE + 32'h004};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, BASE + 32'h100, 1'b1, 1'b1, BASE + 32'h00C, BASE + 32'h008};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, BASE + 32'h100, BASE + 32'h00C};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, BASE + 32'h104, BASE + 32'h100};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, BASE + 32'h108, BASE + 32'h104};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, BASE + 32'h108, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0, BASE + 32'h108, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1, BASE + 32'h10C, BASE + 32'h108};

    rst_n = 1'b1;
    do_reset();
    check("first_req",  {31'b0, bus.IMem_Req}, 32'd1);

    // Reset state, observed while reset is held.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_req",   {31'b0, bus.IMem_Req},    32'd0);
    check("rst_valid", {31'b0, bus.Instr_Valid}, 32'd0);
    check("rst_instr", bus.Instr,                32'd0);
    check("rst_pc4",   bus.Instr_PC_Plus4,       32'd0);

    // ---- directed table: zero-wait stream, 3-cycle stall with skid, branch ----
    do_reset();
    for (int i = 0; i < 13; i++) begin
      check($sformatf("v%0d_req", i),   {31'b0, bus.IMem_Req},    {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_valid", i), {31'b0, bus.Instr_Valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d_addr", i),  bus.IMem_Addr,            vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_instr", i), bus.Instr,          vecs[i].e_instr);
        check($sformatf("v%0d_pc4", i),   bus.Instr_PC_Plus4, vecs[i].e_instr + 32'd4);
      end
      cyc(vecs[i].stall, vecs[i].ack, vecs[i].redir, vecs[i].alt);
    end

    // ---- redirect with memory ack delayed two cycles: pending target ----
    do_reset();
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("dly_pc4_branch", bus.Instr_PC_Plus4, BASE + 32'h00C);
    cyc(1'b0, 1'b0, 1'b1, BASE + 32'h100);
    check("dly_addr1",  bus.IMem_Addr,            BASE + 32'h00C);
    check("dly_valid1", {31'b0, bus.Instr_Valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("dly_addr2",  bus.IMem_Addr,            BASE + 32'h00C);
    check("dly_req2",   {31'b0, bus.IMem_Req},    32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("dly_slot",   bus.Instr,                BASE + 32'h00C);
    check("dly_addr3",  bus.IMem_Addr,            BASE + 32'h100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("dly_target", bus.Instr,                BASE + 32'h100);
    check("dly_tpc4",   bus.Instr_PC_Plus4,       BASE + 32'h104);

    // ---- redirect while stalled with skid full, then release ----
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("skr_req_off", {31'b0, bus.IMem_Req}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, BASE + 32'h200);
    check("skr_frozen",  bus.Instr,             BASE + 32'h000);
    check("skr_req_off2", {31'b0, bus.IMem_Req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("skr_instr",   bus.Instr,             BASE + 32'h004);
    check("skr_pc4",     bus.Instr_PC_Plus4,    BASE + 32'h008);
    check("skr_req_on",  {31'b0, bus.IMem_Req}, 32'd1);
    check("skr_addr",    bus.IMem_Addr,         BASE + 32'h200);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("skr_target",  bus.Instr,             BASE + 32'h200);

    // ---- reset asserted mid-request, late ack while held ----
    do_reset();
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("mr_addr", bus.IMem_Addr, BASE + 32'h010);
    #1 rst_n = 1'b0;
    #1;
    check("mr_req",   {31'b0, bus.IMem_Req},    32'd0);
    check("mr_valid", {31'b0, bus.Instr_Valid}, 32'd0);
    bus.IMem_Ack  = 1'b1;
    bus.IMem_Data = 32'hDEADBEEF;
    @(negedge clk);
    bus.IMem_Ack = 1'b0;
    rst_n = 1'b1;
    #1;
    check("mr_restart_addr", bus.IMem_Addr,            BASE);
    check("mr_restart_val",  {31'b0, bus.Instr_Valid}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("mr_first", bus.Instr, BASE);

    // ---- randomized traffic against the delivered-stream model ----
    do_reset();
    exp_next  = BASE;
    after_v   = 1'b0;
    after_pc  = '0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    n_cons    = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_req && !prev_ack) begin
        check("rnd_addr_hold", bus.IMem_Addr, prev_addr);
        check("rnd_req_hold",  {31'b0, bus.IMem_Req}, 32'd1);
      end
      stall   = ($urandom % 10) < 3;
      ack     = ($urandom % 10) < 6;
      consume = bus.Instr_Valid && !stall;
      redir   = consume && (($urandom % 4) == 0);
      rnd     = $urandom;
      alt     = {rnd[31:2], 2'b00};
      if (consume) begin
        check("rnd_instr", bus.Instr,          exp_next);
        check("rnd_pc4",   bus.Instr_PC_Plus4, exp_next + 32'd4);
        exp_next = after_v ? after_pc : exp_next + 32'd4;
        after_v  = redir;
        after_pc = alt;
        n_cons++;
      end
      prev_req  = bus.IMem_Req;
      prev_ack  = ack;
      prev_addr = bus.IMem_Addr;
      cyc(stall, ack, redir, alt);
    end
    check("rnd_progress", {31'b0, n_cons >= 500}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
